// File: rtl/top.sv
// Fully pipelined 8-point radix-2 DIT FFT for real 16-bit input samples.
// There are three registered butterfly stages of 17, 18 and 19 bits, and each output is saturated to 16 bits.
module top (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] x0,
  input  logic signed [15:0] x1,
  input  logic signed [15:0] x2,
  input  logic signed [15:0] x3,
  input  logic signed [15:0] x4,
  input  logic signed [15:0] x5,
  input  logic signed [15:0] x6,
  input  logic signed [15:0] x7,
  output logic signed [15:0] y0_re,
  output logic signed [15:0] y0_im,
  output logic signed [15:0] y1_re,
  output logic signed [15:0] y1_im,
  output logic signed [15:0] y2_re,
  output logic signed [15:0] y2_im,
  output logic signed [15:0] y3_re,
  output logic signed [15:0] y3_im,
  output logic signed [15:0] y4_re,
  output logic signed [15:0] y4_im,
  output logic signed [15:0] y5_re,
  output logic signed [15:0] y5_im,
  output logic signed [15:0] y6_re,
  output logic signed [15:0] y6_im,
  output logic signed [15:0] y7_re,
  output logic signed [15:0] y7_im
);

  // Multiply by Q15 0.7071 (23170) and round half up.
  function automatic logic signed [18:0] cmul(input logic signed [18:0] v);
    logic signed [34:0] p;
    p = 35'(v) * 35'sd23170 + 35'sd16384;
    return 19'(p >>> 15);
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
    if (v > 19'sd32767)       return 16'sh7fff;
    else if (v < -19'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  logic signed [15:0] x [8];
  assign x[0] = x0;  assign x[1] = x1;  assign x[2] = x2;  assign x[3] = x3;
  assign x[4] = x4;  assign x[5] = x5;  assign x[6] = x6;  assign x[7] = x7;

  // Stage 1 results are real: index 2m is the sum of pair m and index 2m+1 is its difference.
  logic signed [16:0] s1 [8], s1_d [8];
  always_comb begin
    s1_d[0] = 17'(x[0]) + 17'(x[4]);
    s1_d[1] = 17'(x[0]) - 17'(x[4]);
    s1_d[2] = 17'(x[2]) + 17'(x[6]);
    s1_d[3] = 17'(x[2]) - 17'(x[6]);
    s1_d[4] = 17'(x[1]) + 17'(x[5]);
    s1_d[5] = 17'(x[1]) - 17'(x[5]);
    s1_d[6] = 17'(x[3]) + 17'(x[7]);
    s1_d[7] = 17'(x[3]) - 17'(x[7]);
  end

  // Stage 2 produces the 4-point DFTs: even half E[k] at index k and odd half O[k] at index 4+k.
  logic signed [17:0] s2_re [8], s2_im [8], s2_re_d [8], s2_im_d [8];
  always_comb begin
    for (int h = 0; h < 8; h += 4) begin
      s2_re_d[h]   = 18'(s1[h])   + 18'(s1[h+2]);
      s2_im_d[h]   = '0;
      s2_re_d[h+1] = 18'(s1[h+1]);
      s2_im_d[h+1] = -18'(s1[h+3]);
      s2_re_d[h+2] = 18'(s1[h])   - 18'(s1[h+2]);
      s2_im_d[h+2] = '0;
      s2_re_d[h+3] = 18'(s1[h+1]);
      s2_im_d[h+3] = 18'(s1[h+3]);
    end
  end

  // Stage 3 computes X[k] = E[k] + W^k O[k] and X[k+4] = E[k] - W^k O[k].
  logic signed [18:0] s3_re [8], s3_im [8], s3_re_d [8], s3_im_d [8];
  always_comb begin
    logic signed [18:0] a, b, sum, dif, t_re, t_im;
    for (int k = 0; k < 4; k++) begin
      a    = 19'(s2_re[4+k]);
      b    = 19'(s2_im[4+k]);
      sum  = a + b;
      dif  = b - a;
      t_re = a;
      t_im = b;
      case (k)
        1:       begin t_re = cmul(sum); t_im = cmul(dif);  end
        2:       begin t_re = b;         t_im = -a;         end
        3:       begin t_re = cmul(dif); t_im = -cmul(sum); end
        default: ;
      endcase
      s3_re_d[k]   = 19'(s2_re[k]) + t_re;
      s3_im_d[k]   = 19'(s2_im[k]) + t_im;
      s3_re_d[k+4] = 19'(s2_re[k]) - t_re;
      s3_im_d[k+4] = 19'(s2_im[k]) - t_im;
    end
  end

  // NOTE: reset is synchronous and wins over capture, so in-flight vectors are dropped on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        s1[i]    <= '0;
        s2_re[i] <= '0;
        s2_im[i] <= '0;
        s3_re[i] <= '0;
        s3_im[i] <= '0;
      end
    end else begin
      s1    <= s1_d;
      s2_re <= s2_re_d;
      s2_im <= s2_im_d;
      s3_re <= s3_re_d;
      s3_im <= s3_im_d;
    end
  end

  assign y0_re = sat16(s3_re[0]);  assign y0_im = sat16(s3_im[0]);
  assign y1_re = sat16(s3_re[1]);  assign y1_im = sat16(s3_im[1]);
  assign y2_re = sat16(s3_re[2]);  assign y2_im = sat16(s3_im[2]);
  assign y3_re = sat16(s3_re[3]);  assign y3_im = sat16(s3_im[3]);
  assign y4_re = sat16(s3_re[4]);  assign y4_im = sat16(s3_im[4]);
  assign y5_re = sat16(s3_re[5]);  assign y5_im = sat16(s3_im[5]);
  assign y6_re = sat16(s3_re[6]);  assign y6_im = sat16(s3_im[6]);
  assign y7_re = sat16(s3_re[7]);  assign y7_im = sat16(s3_im[7]);

endmodule

// File: tb/tb_top.sv
// Directed testbench for the 8-point FFT pipeline.
// It applies hand-computed vectors from a table and then runs streaming and mid-stream reset sequences.
module tb_top;

  typedef struct {
    string           name;
    logic [7:0][15:0] x;
    logic [7:0][15:0] re;
    logic [7:0][15:0] im;
  } vec_t;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] x    [8];
  logic signed [15:0] y_re [8];
  logic signed [15:0] y_im [8];

  int n_cmp  = 0;
  int n_fail = 0;

  vec_t vecs [$];

  always #5 clk = ~clk;

  top dut (
    .clk(clk), .reset(reset),
    .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
    .x4(x[4]), .x5(x[5]), .x6(x[6]), .x7(x[7]),
    .y0_re(y_re[0]), .y0_im(y_im[0]), .y1_re(y_re[1]), .y1_im(y_im[1]),
    .y2_re(y_re[2]), .y2_im(y_im[2]), .y3_re(y_re[3]), .y3_im(y_im[3]),
    .y4_re(y_re[4]), .y4_im(y_im[4]), .y5_re(y_re[5]), .y5_im(y_im[5]),
    .y6_re(y_re[6]), .y6_im(y_im[6]), .y7_re(y_re[7]), .y7_im(y_im[7])
  );

  function automatic vec_t blank(input string n);
    vec_t v;
    v.name = n;
    v.x    = '0;
    v.re   = '0;
    v.im   = '0;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s/%s y%0d_re", tag, v.name, k), y_re[k], v.re[k]);
      check($sformatf("%s/%s y%0d_im", tag, v.name, k), y_im[k], v.im[k]);
    end
  endtask

  task automatic drive(input vec_t v);
    for (int i = 0; i < 8; i++) x[i] = v.x[i];
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v, zero, dc, imp, nyq;
    int sr [8] = '{1000, 707, 0, -707, -1000, -707, 0, 707};
    int si [8] = '{0, -707, -1000, -707, 0, 707, 1000, 707};
    int tr [8] = '{1000, 0, -1000, 0, 1000, 0, -1000, 0};
    int ti [8] = '{0, -1000, 0, 1000, 0, -1000, 0, 1000};
    int ur [8] = '{2000, 0, 0, 0, -2000, 0, 0, 0};
    int ui [8] = '{0, -1414, 0, -1414, 0, 1414, 0, 1414};

    zero = blank("zero");
    dc = blank("dc");
    for (int i = 0; i < 8; i++) dc.x[i] = 16'd8;
    dc.re[0] = 16'd64;
    vecs.push_back(dc);

    imp = blank("impulse");
    imp.x[0] = 16'd100;
    for (int k = 0; k < 8; k++) imp.re[k] = 16'd100;
    vecs.push_back(imp);

    v = blank("shifted");
    v.x[1] = 16'd1000;
    for (int k = 0; k < 8; k++) begin v.re[k] = 16'(sr[k]); v.im[k] = 16'(si[k]); end
    vecs.push_back(v);

    nyq = blank("nyquist");
    for (int i = 0; i < 8; i++) nyq.x[i] = (i % 2 == 0) ? 16'sd1000 : -16'sd1000;
    nyq.re[4] = 16'd8000;
    vecs.push_back(nyq);

    v = blank("x2_imp");
    v.x[2] = 16'd1000;
    for (int k = 0; k < 8; k++) begin v.re[k] = 16'(tr[k]); v.im[k] = 16'(ti[k]); end
    vecs.push_back(v);

    v = blank("x1_x3");
    v.x[1] = 16'd1000;
    v.x[3] = 16'd1000;
    for (int k = 0; k < 8; k++) begin v.re[k] = 16'(ur[k]); v.im[k] = 16'(ui[k]); end
    vecs.push_back(v);

    v = blank("sat_pos");
    for (int i = 0; i < 8; i++) v.x[i] = 16'h7fff;
    v.re[0] = 16'h7fff;
    vecs.push_back(v);

    v = blank("sat_neg");
    for (int i = 0; i < 8; i++) v.x[i] = 16'h8000;
    v.re[0] = 16'h8000;
    vecs.push_back(v);

    // Reset is held while non-zero inputs are driven, and the outputs must stay at zero.
    reset = 1'b1;
    drive(dc);
    repeat (3) settle();
    check_vec(zero, "reset");

    // Each table vector is applied alone and checked after three edges.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = 1'b0;
      drive(vecs[i]);
      repeat (3) settle();
      check_vec(vecs[i], "table");
    end

    // The pipeline is flushed, then three vectors are streamed back to back.
    @(negedge clk);
    drive(zero);
    repeat (3) settle();
    @(negedge clk); drive(dc);
    settle();
    @(negedge clk); drive(imp);
    settle();
    check_vec(zero, "latency");
    @(negedge clk); drive(nyq);
    settle();
    check_vec(dc, "stream");
    @(negedge clk); drive(zero);
    settle();
    check_vec(imp, "stream");
    settle();
    check_vec(nyq, "stream");

    // Reset is asserted mid-stream, and the in-flight dc and impulse vectors must be dropped.
    @(negedge clk); drive(dc);
    settle();
    @(negedge clk); drive(imp);
    settle();
    @(negedge clk); drive(nyq); reset = 1'b1;
    settle();
    check_vec(zero, "midreset");
    @(negedge clk); reset = 1'b0; drive(imp);
    settle();
    check_vec(zero, "flush1");
    settle();
    check_vec(zero, "flush2");
    settle();
    check_vec(imp, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have ports x0..x7, input, 16 bits signed each: the real-valued time-domain samples x[n]; the imaginary part is implicitly 0.
REQ-004 The block SHALL have ports y0_re..y7_re, output, 16 bits signed each: the real part of frequency bin X[k].
REQ-005 The block SHALL have ports y0_im..y7_im, output, 16 bits signed each: the imaginary part of X[k].
REQ-006 Port order SHALL be: clk, reset, x0..x7, then y0_re, y0_im, y1_re, y1_im, ... y7_re, y7_im.
REQ-007 The block SHALL have no parameters, no handshake, and no valid strobe; it accepts a new 8-sample vector every clock.

Function
REQ-008 The block SHALL compute the 8-point forward DFT X[k] = sum over n of x[n]*exp(-j*2*pi*n*k/8), for k = 0..7, with unity gain (no 1/N scaling).
REQ-009 The computation SHALL be a radix-2 decimation-in-time structure: 3 butterfly stages; stage-1 pairs are (x0,x4), (x2,x6), (x1,x5), (x3,x7).
REQ-010 Stage 1 and stage 2 SHALL use only twiddles 1 and -j, which are exact: (a+jb)*(-j) = b - ja.
REQ-011 Stage 3 SHALL apply W8^1 to (a+jb) as re = C(a+b), im = C(b-a), and W8^3 as re = C(b-a), im = -C(a+b).
REQ-012 C(v) SHALL be (v*23170 + 16384) arithmetic-shifted right by 15, i.e. Q15 0.7071 with round-half-up.
REQ-013 Internal datapaths SHALL grow one bit per stage (17, 18, 19 bits), with no overflow inside the pipeline.
REQ-014 Each final output SHALL be saturated to [-32768, +32767] when driven onto its 16-bit port.
REQ-015 The pipeline SHALL be three register stages: the stage-1, stage-2 and stage-3 results are each registered.
REQ-016 Latency SHALL be 3 cycles: inputs sampled at edge N appear on the outputs after edge N+2 and are stable until edge N+3.
REQ-017 Throughput SHALL be one transform per clock, fully pipelined.
REQ-018 Before the first reset, or until the pipeline fills, output values are don't-care.

Reset
REQ-019 When reset=1 at a rising edge, all pipeline registers SHALL clear to 0, so all 16 outputs read 0 after that edge.
REQ-020 Reset asserted mid-stream SHALL discard all in-flight vectors; no partial results appear.
REQ-021 After reset deasserts, the first valid result SHALL appear 3 edges after the first edge with reset=0 and stable inputs.
REQ-022 Reset SHALL take priority over input capture on the same edge.
REQ-023 Only reset events that coincide with a rising clock edge SHALL have an effect.

Verification
REQ-024 Directed scenario, DC: all x = 8 -> y0 = (64, 0); y1..y7 = (0, 0), 3 cycles after the inputs are applied.
REQ-025 Directed scenario, impulse: x0 = 100, others 0 -> every yk = (100, 0).
REQ-026 Directed scenario, shifted impulse: x1 = 1000, others 0 -> y0 = (1000, 0), y1 = (707, -707), y2 = (0, -1000), y3 = (-707, -707), y4 = (-1000, 0), y5 = (-707, 707), y6 = (0, 1000), y7 = (707, 707).
REQ-027 Directed scenario, Nyquist: x = +1000, -1000 alternating starting at x0 -> y4 = (8000, 0); all other bins 0.
REQ-028 Directed scenario, saturation: all x = 32767 -> y0_re = 32767, all else 0; then all x = -32768 -> y0_re = -32768, all else 0.
REQ-029 Directed scenario, streaming and reset: apply the DC, impulse and Nyquist vectors on consecutive cycles -> results appear on consecutive cycles after 3-cycle latency; assert reset for 1 edge mid-stream -> all outputs 0 on the next cycle, and stale vectors never appear.
